// File: rtl/alu_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_seq_pkg : shared state encoding and constants for alu_op_sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int   DATA_W = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_op_sequencer_if : request, ALU-drive and response channels of the sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  import alu_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_sub;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] alu_opa;
  logic [DATA_W-1:0] alu_opb;
  logic              alu_sel;
  logic [DATA_W-1:0] alu_res;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_res;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_zero;
  logic              rsp_neg;
  logic              rsp_carry;
  logic              rsp_ovf;
  logic [CNT_W-1:0]  op_count;

  // master: the sequencer itself
  modport master (
    input  req_valid, req_a, req_b, req_sub, req_tag, alu_res, rsp_ready,
    output req_ready, alu_opa, alu_opb, alu_sel,
    output rsp_valid, rsp_res, rsp_tag, rsp_zero, rsp_neg, rsp_carry, rsp_ovf, op_count
  );

  // slave: control path, ALU instance and response consumer
  modport slave (
    output req_valid, req_a, req_b, req_sub, req_tag, alu_res, rsp_ready,
    input  req_ready, alu_opa, alu_opb, alu_sel,
    input  rsp_valid, rsp_res, rsp_tag, rsp_zero, rsp_neg, rsp_carry, rsp_ovf, op_count
  );

endinterface
`default_nettype wire

// File: rtl/alu_flags.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_flags : combinational zero/neg/carry/overflow from operands, select and result
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_flags
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_res,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_carry,
  output logic              o_ovf
);

  logic w_is_sub;
  logic w_add_cout;
  logic w_a_msb;
  logic w_b_msb;
  logic w_r_msb;

  assign w_is_sub = (i_sel == OP_SUB);
  assign w_a_msb  = i_a[DATA_W-1];
  assign w_b_msb  = i_b[DATA_W-1];
  assign w_r_msb  = i_res[DATA_W-1];

  // A + B overflows the data width exactly when A exceeds (all-ones - B) = ~B
  assign w_add_cout = (i_a > ~i_b);

  assign o_zero  = (i_res == '0);
  assign o_neg   = w_r_msb;
  assign o_carry = w_is_sub ? (i_a < i_b) : w_add_cout;
  assign o_ovf   = w_is_sub ? ((w_a_msb != w_b_msb) && (w_r_msb != w_a_msb))
                            : ((w_a_msb == w_b_msb) && (w_r_msb != w_a_msb));

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_op_sequencer : issues one request at a time to the registered ALU and returns a flagged response
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.master bus
);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_alu_opa;
  logic [DATA_W-1:0] r_alu_opb;
  logic              r_alu_sel;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_rsp_res;
  logic [TAG_W-1:0]  r_rsp_tag;
  logic              r_zero;
  logic              r_neg;
  logic              r_carry;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_op_count;

  logic              w_zero;
  logic              w_neg;
  logic              w_carry;
  logic              w_ovf;

  // The ALU operand registers only change on accept, so they double as the
  // captured operand copies the flags are derived from.
  alu_flags u_flags (
    .i_a     (r_alu_opa),
    .i_b     (r_alu_opb),
    .i_sel   (r_alu_sel),
    .i_res   (bus.alu_res),
    .o_zero  (w_zero),
    .o_neg   (w_neg),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_alu_opa   <= '0;
      r_alu_opb   <= '0;
      r_alu_sel   <= OP_ADD;
      r_tag       <= '0;
      r_rsp_res   <= '0;
      r_rsp_tag   <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_alu_opa   <= bus.req_a;
            r_alu_opb   <= bus.req_b;
            r_alu_sel   <= bus.req_sub;
            r_tag       <= bus.req_tag;
            r_req_ready <= 1'b0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_rsp_res   <= bus.alu_res;
          r_rsp_tag   <= r_tag;
          r_zero      <= w_zero;
          r_neg       <= w_neg;
          r_carry     <= w_carry;
          r_ovf       <= w_ovf;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            if (r_op_count != {CNT_W{1'b1}}) begin
              r_op_count <= r_op_count + CNT_W'(1);
            end
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.alu_opa   = r_alu_opa;
  assign bus.alu_opb   = r_alu_opb;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_res   = r_rsp_res;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_zero  = r_zero;
  assign bus.rsp_neg   = r_neg;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer : randomized self-checking bench with an arithmetic reference model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int TAG_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [7:0]       res;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) sif ();

  alu_op_sequencer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  // registered add/subtract ALU the sequencer drives
  always @(posedge clk) begin
    sif.alu_res <= sif.alu_sel ? (sif.alu_opa - sif.alu_opb) : (sif.alu_opa + sif.alu_opb);
  end

  function automatic rsp_t model(int a, int b, bit sub, int tag);
    rsp_t e;
    int r, m, sa, sb, sr;
    r  = sub ? a - b : a + b;
    m  = (r + 256) % 256;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sr = sub ? sa - sb : sa + sb;
    e.res   = 8'(m);
    e.tag   = TAG_W'(tag);
    e.zero  = (m == 0);
    e.neg   = (m >= 128);
    e.carry = sub ? (a < b) : (r > 255);
    e.ovf   = (sr > 127) || (sr < -128);
    return e;
  endfunction

  function automatic rsp_t observed();
    rsp_t o;
    o.res   = sif.rsp_res;
    o.tag   = sif.rsp_tag;
    o.zero  = sif.rsp_zero;
    o.neg   = sif.rsp_neg;
    o.carry = sif.rsp_carry;
    o.ovf   = sif.rsp_ovf;
    return o;
  endfunction

  function automatic logic [63:0] snapshot();
    return {25'd0, sif.req_ready, sif.rsp_valid, sif.alu_opa, sif.alu_opb, sif.alu_sel,
            sif.rsp_res, sif.rsp_tag, sif.rsp_zero, sif.rsp_neg, sif.rsp_carry, sif.rsp_ovf,
            sif.op_count};
  endfunction

  function automatic int next_count(int c);
    return (c == CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sif.rsp_valid === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [TAG_W-1:0] tag, output int lat);
    int n;
    lat = -1;
    n   = 0;
    while (sif.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (sif.req_ready !== 1'b1) return;
    sif.req_a     = a;
    sif.req_b     = b;
    sif.req_sub   = sub;
    sif.req_tag   = tag;
    sif.req_valid = 1'b1;
    tick();
    sif.req_valid = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic handshake();
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    exp_count = next_count(exp_count);
  endtask

  task automatic test_reset();
    logic [63:0] exp_v;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_count = 0;
    exp_v = {25'd0, 1'b1, 38'd0};
    checks++;
    if (snapshot() !== exp_v) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", snapshot(), exp_v);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_v;
    bit          seen;
    sif.req_a     = 8'hA5;
    sif.req_b     = 8'h3C;
    sif.req_sub   = 1'b1;
    sif.req_tag   = 4'h9;
    sif.req_valid = 1'b1;
    tick();
    sif.req_valid = 1'b0;
    checks++;
    if ({sif.req_ready, sif.alu_opa, sif.alu_opb, sif.alu_sel} !== {1'b0, 8'hA5, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL issue_load: got %h expected %h",
               {sif.req_ready, sif.alu_opa, sif.alu_opb, sif.alu_sel}, {1'b0, 8'hA5, 8'h3C, 1'b1});
    end
    tick();
    rst_n = 1'b0;
    #2;
    exp_v = {25'd0, 1'b1, 38'd0};
    checks++;
    if (snapshot() !== exp_v) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", snapshot(), exp_v);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sif.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if ({seen, sif.req_ready, sif.op_count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      errors++;
      $display("FAIL reset_drop: got seen=%0b ready=%0b count=%0d expected 0 1 0",
               seen, sif.req_ready, sif.op_count);
    end
  endtask

  task automatic test_directed();
    logic [7:0]       ta [5];
    logic [7:0]       tb [5];
    logic             ts [5];
    logic [TAG_W-1:0] tt [5];
    logic [7:0]       er [5];
    logic [3:0]       ef [5];
    int               lat;
    ta = '{8'h0F, 8'h05, 8'h00, 8'h7F, 8'hFF};
    tb = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h01};
    ts = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_ADD};
    tt = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
    er = '{8'h10, 8'h00, 8'hFF, 8'h80, 8'h00};
    // flags packed as {zero, neg, carry, ovf}
    ef = '{4'b0000, 4'b1000, 4'b0110, 4'b0101, 4'b1010};
    for (int i = 0; i < 5; i++) begin
      do_txn(ta[i], tb[i], ts[i], tt[i], lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d expected 2", i, lat);
      end
      checks++;
      if (observed() !== {er[i], tt[i], ef[i]}) begin
        errors++;
        $display("FAIL directed[%0d] rsp: got %h expected %h", i, observed(), {er[i], tt[i], ef[i]});
      end
      handshake();
      checks++;
      if (sif.op_count !== CNT_W'(exp_count)) begin
        errors++;
        $display("FAIL directed[%0d] op_count: got %0d expected %0d", i, sif.op_count, exp_count);
      end
    end
  endtask

  task automatic test_random();
    int   a, b, t, lat;
    bit   s;
    rsp_t e;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      s = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 15);
      e = model(a, b, s, t);
      do_txn(8'(a), 8'(b), s, TAG_W'(t), lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL random[%0d] latency: got %0d expected 2", i, lat);
      end
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL random[%0d] rsp a=%0d b=%0d sub=%0b: got %h expected %h", i, a, b, s, observed(), e);
      end
      handshake();
      checks++;
      if (sif.op_count !== CNT_W'(exp_count)) begin
        errors++;
        $display("FAIL random[%0d] op_count: got %0d expected %0d", i, sif.op_count, exp_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t q[$];
    rsp_t e;
    int   accepts, last_acc, cyc, a, b, t;
    bit   s, acc_now;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_count = 0;
    accepts   = 0;
    last_acc  = 0;
    cyc       = 0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    s = 1'($urandom_range(0, 1));
    t = 0;
    sif.req_a = 8'(a); sif.req_b = 8'(b); sif.req_sub = s; sif.req_tag = TAG_W'(t);
    sif.req_valid = 1'b1;
    sif.rsp_ready = 1'b1;
    while ((accepts < 8 || q.size() > 0) && cyc < 200) begin
      acc_now = (sif.req_valid === 1'b1) && (sif.req_ready === 1'b1);
      if (sif.rsp_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected response: got %h expected none", observed());
        end else begin
          e = q.pop_front();
          if (observed() !== e) begin
            errors++;
            $display("FAIL b2b rsp: got %h expected %h", observed(), e);
          end
        end
      end
      if (acc_now) begin
        q.push_back(model(a, b, s, t));
        if (accepts > 0) begin
          checks++;
          if (cyc - last_acc !== 4) begin
            errors++;
            $display("FAIL b2b issue_period: got %0d expected 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
        accepts++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (accepts < 8) begin
          a = $urandom_range(0, 255);
          b = $urandom_range(0, 255);
          s = 1'($urandom_range(0, 1));
          t = accepts;
          sif.req_a = 8'(a); sif.req_b = 8'(b); sif.req_sub = s; sif.req_tag = TAG_W'(t);
        end else begin
          sif.req_valid = 1'b0;
        end
      end
    end
    sif.req_valid = 1'b0;
    sif.rsp_ready = 1'b0;
    exp_count = 8;
    checks++;
    if (accepts !== 8 || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b completion: got accepts=%0d pending=%0d expected 8 0", accepts, q.size());
    end
    checks++;
    if (sif.op_count !== CNT_W'(8)) begin
      errors++;
      $display("FAIL b2b op_count: got %0d expected 8", sif.op_count);
    end
  endtask

  task automatic test_backpressure();
    int   a1, b1, a2, b2, lat;
    bit   seen;
    rsp_t e1, e2;
    a1 = $urandom_range(0, 255);
    b1 = $urandom_range(0, 255);
    a2 = $urandom_range(0, 255);
    b2 = $urandom_range(0, 255);
    e1 = model(a1, b1, 1'b0, 10);
    e2 = model(a2, b2, 1'b1, 11);
    do_txn(8'(a1), 8'(b1), OP_ADD, 4'd10, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bp latency: got %0d expected 2", lat);
    end
    sif.req_a = 8'(a2); sif.req_b = 8'(b2); sif.req_sub = OP_SUB; sif.req_tag = 4'd11;
    sif.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({sif.rsp_valid, sif.req_ready, observed()} !== {1'b1, 1'b0, e1}) begin
        errors++;
        $display("FAIL bp hold[%0d]: got %h expected %h", i,
                 {sif.rsp_valid, sif.req_ready, observed()}, {1'b1, 1'b0, e1});
      end
    end
    handshake();
    checks++;
    if ({sif.rsp_valid, sif.req_ready, sif.op_count} !== {1'b0, 1'b1, CNT_W'(exp_count)}) begin
      errors++;
      $display("FAIL bp release: got valid=%0b ready=%0b count=%0d expected 0 1 %0d",
               sif.rsp_valid, sif.req_ready, sif.op_count, exp_count);
    end
    tick();
    sif.req_valid = 1'b0;
    checks++;
    if (sif.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp next_accept: got req_ready=%0b expected 0", sif.req_ready);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 2 || observed() !== e2) begin
      errors++;
      $display("FAIL bp second_rsp: got lat=%0d rsp=%h expected lat=2 rsp=%h", lat, observed(), e2);
    end
    handshake();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sif.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if ({seen, sif.op_count} !== {1'b0, CNT_W'(exp_count)}) begin
      errors++;
      $display("FAIL bp single_completion: got extra=%0b count=%0d expected 0 %0d",
               seen, sif.op_count, exp_count);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    sif.req_valid = 1'b0;
    sif.req_a     = '0;
    sif.req_b     = '0;
    sif.req_sub   = 1'b0;
    sif.req_tag   = '0;
    sif.rsp_ready = 1'b0;
    test_reset();
    test_reset_mid();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
